// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control unit: owns the PC and IR, sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// and drives datapath selects, memory strobes and register numbers from the latched instruction.
module legv8_multicycle_ctrl #(
    parameter int unsigned         PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter bit                  CBNZ_EN  = 1'b1
) (
    input  logic                CLOCK,
    input  logic                RESET_N,
    output logic                FETCH_REQ,
    input  logic                INSTR_VALID,
    input  logic [31:0]         INSTRUCTION,
    output logic [PC_WIDTH-1:0] PC,
    input  logic                ALU_ZERO,
    input  logic                MEM_READY,
    output logic                REG2LOC,
    output logic                ALUSRC,
    output logic                MEM2REG,
    output logic                MEMREAD,
    output logic                MEMWRITE,
    output logic                REGWRITE,
    output logic [1:0]          ALU_OP,
    output logic [4:0]          READ_REG_1,
    output logic [4:0]          READ_REG_2,
    output logic [4:0]          WRITE_REG,
    output logic [PC_WIDTH-1:0] IMM,
    output logic                ILLEGAL
);

    localparam logic [2:0] StFetch   = 3'd0;
    localparam logic [2:0] StDecode  = 3'd1;
    localparam logic [2:0] StExecute = 3'd2;
    localparam logic [2:0] StMem     = 3'd3;
    localparam logic [2:0] StWb      = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;

    logic is_b, is_cbz, is_cbnz, is_addi, is_subi, is_ldur, is_stur, is_rtype, is_illegal;
    logic is_branch, is_mem, active;
    logic reg2loc, alusrc, mem2reg;
    logic [1:0] alu_op;
    logic [PC_WIDTH-1:0] imm_raw, pc_plus4, branch_tgt;
    logic                taken;

    // Priority decode of the latched instruction word.
    always_comb begin
        is_b       = 1'b0;
        is_cbz     = 1'b0;
        is_cbnz    = 1'b0;
        is_addi    = 1'b0;
        is_subi    = 1'b0;
        is_ldur    = 1'b0;
        is_stur    = 1'b0;
        is_rtype   = 1'b0;
        is_illegal = 1'b0;
        if (ir_q[31:26] == 6'b000101) begin
            is_b = 1'b1;
        end else if (ir_q[31:24] == 8'b10110100) begin
            is_cbz = 1'b1;
        end else if (CBNZ_EN && (ir_q[31:24] == 8'b10110101)) begin
            is_cbnz = 1'b1;
        end else if (ir_q[31:22] == 10'b1001000100) begin
            is_addi = 1'b1;
        end else if (ir_q[31:22] == 10'b1101000100) begin
            is_subi = 1'b1;
        end else begin
            case (ir_q[31:21])
                11'b11111000010: is_ldur  = 1'b1;
                11'b11111000000: is_stur  = 1'b1;
                11'b10001011000,
                11'b11001011000,
                11'b10001010000,
                11'b10101010000: is_rtype = 1'b1;
                default:         is_illegal = 1'b1;
            endcase
        end
    end

    assign is_branch = is_b | is_cbz | is_cbnz;
    assign is_mem    = is_ldur | is_stur;

    always_comb begin
        reg2loc = is_stur | is_cbz | is_cbnz;
        alusrc  = is_addi | is_subi | is_ldur | is_stur;
        mem2reg = is_ldur;
        alu_op  = 2'b00;
        if (is_rtype) begin
            alu_op = 2'b10;
        end else if (is_addi | is_subi) begin
            alu_op = 2'b11;
        end else if (is_branch) begin
            alu_op = 2'b01;
        end
    end

    always_comb begin
        imm_raw = '0;
        if (is_ldur | is_stur) begin
            imm_raw = {{(PC_WIDTH - 9){ir_q[20]}}, ir_q[20:12]};
        end else if (is_addi | is_subi) begin
            imm_raw = {{(PC_WIDTH - 12){1'b0}}, ir_q[21:10]};
        end else if (is_cbz | is_cbnz) begin
            imm_raw = {{(PC_WIDTH - 19){ir_q[23]}}, ir_q[23:5]};
        end else if (is_b) begin
            imm_raw = {{(PC_WIDTH - 26){ir_q[25]}}, ir_q[25:0]};
        end
    end

    assign pc_plus4   = pc_q + PC_WIDTH'(4);
    assign branch_tgt = pc_q + (imm_raw << 2);
    assign taken      = is_b | (is_cbz & ALU_ZERO) | (is_cbnz & ~ALU_ZERO);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            StFetch: begin
                if (INSTR_VALID) begin
                    ir_d    = INSTRUCTION;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (is_illegal) begin
                    pc_d    = pc_plus4;
                    state_d = StFetch;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: begin
                if (is_branch) begin
                    pc_d    = taken ? branch_tgt : pc_plus4;
                    state_d = StFetch;
                end else if (is_mem) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (MEM_READY) begin
                    if (is_ldur) begin
                        state_d = StWb;
                    end else begin
                        pc_d    = pc_plus4;
                        state_d = StFetch;
                    end
                end
            end
            StWb: begin
                pc_d    = pc_plus4;
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Everything except the fetch request is quiet in FETCH, which also covers reset.
    assign active     = (state_q != StFetch);
    assign FETCH_REQ  = RESET_N & (state_q == StFetch);
    assign PC         = pc_q;
    assign REG2LOC    = active & reg2loc;
    assign ALUSRC     = active & alusrc;
    assign MEM2REG    = active & mem2reg;
    assign ALU_OP     = active ? alu_op : 2'b00;
    assign MEMREAD    = (state_q == StMem) & is_ldur;
    assign MEMWRITE   = (state_q == StMem) & is_stur;
    assign REGWRITE   = (state_q == StWb);
    assign ILLEGAL    = (state_q == StDecode) & is_illegal;
    assign READ_REG_1 = active ? ir_q[9:5] : 5'd0;
    assign READ_REG_2 = active ? (reg2loc ? ir_q[4:0] : ir_q[20:16]) : 5'd0;
    assign WRITE_REG  = active ? ir_q[4:0] : 5'd0;
    assign IMM        = active ? imm_raw : '0;

endmodule
